// File: rtl/shift_right_32_iter_if.sv
// Request/response bundle between the execute-stage controller (master)
// and the iterative right shifter (slave).
interface shift_right_32_iter_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             start;
   logic [WIDTH-1:0] in;
   logic [SHW-1:0]   shamt;
   logic             arith;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;

   modport master (output start, in, shamt, arith, input out, busy, done);
   modport slave  (input start, in, shamt, arith, output out, busy, done);
endinterface

// File: rtl/shift_right_32_iter.sv
// Multi-cycle SRL/SRA: retires up to two bit positions per clock using a
// 2-bit and a 1-bit stage, under a start/busy/done handshake.
module shift_right_32_iter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input logic                  clock,
   input logic                  reset,
   shift_right_32_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SHW-1:0]   rem_q, rem_d;
   logic             fill_q, fill_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      fill_d  = fill_q;
      out_d   = out_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               data_d  = bus.in;
               rem_d   = bus.shamt;
               // Sign is frozen here so later data shifts cannot change it.
               fill_d  = bus.arith & bus.in[WIDTH-1];
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (rem_q >= SHW'(2)) begin
               data_d = {fill_q, fill_q, data_q[WIDTH-1:2]};
               rem_d  = rem_q - SHW'(2);
            end else if (rem_q == SHW'(1)) begin
               data_d = {fill_q, data_q[WIDTH-1:1]};
               rem_d  = '0;
            end else begin
               out_d   = data_q;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Flags come from the next state so they are clean flop outputs.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         fill_q  <= 1'b0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         fill_q  <= fill_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule
